// File: rtl/cpu_axi_bridge.sv
// CPU-to-AXI3 bridge: merges the instruction and data SRAM-like ports onto
// one AXI3 master with multiple outstanding reads per port and multiple
// outstanding writes, fair AR arbitration and back-to-back issue.
//
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   inst_sram_*                   instruction port (reads only)
//   data_sram_*                   data port (reads and writes)
//   ar*/r*/aw*/w*/b*              AXI3 master channels
module cpu_axi_bridge #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned MAX_RD = 4,
    parameter int unsigned MAX_WR = 4
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  inst_sram_req,
    input  logic                  inst_sram_wr,
    input  logic [2:0]            inst_sram_size,
    input  logic [31:0]           inst_sram_addr,
    input  logic [DATA_W/8-1:0]   inst_sram_wstrb,
    input  logic [DATA_W-1:0]     inst_sram_wdata,
    output logic                  inst_sram_addr_ok,
    output logic                  inst_sram_data_ok,
    output logic [DATA_W-1:0]     inst_sram_rdata,

    input  logic                  data_sram_req,
    input  logic                  data_sram_wr,
    input  logic [2:0]            data_sram_size,
    input  logic [31:0]           data_sram_addr,
    input  logic [DATA_W/8-1:0]   data_sram_wstrb,
    input  logic [DATA_W-1:0]     data_sram_wdata,
    output logic                  data_sram_addr_ok,
    output logic                  data_sram_data_ok,
    output logic [DATA_W-1:0]     data_sram_rdata,

    output logic [ID_W-1:0]       arid,
    output logic [31:0]           araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [ID_W-1:0]       rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,

    output logic [ID_W-1:0]       awid,
    output logic [31:0]           awaddr,
    output logic [3:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [1:0]            awlock,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,

    output logic [ID_W-1:0]       wid,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,

    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned RD_CW  = $clog2(MAX_RD + 1);
    localparam int unsigned WR_CW  = $clog2(MAX_WR + 1);

    // State
    logic [RD_CW-1:0]  ird_cnt_q, ird_cnt_d;
    logic [RD_CW-1:0]  drd_cnt_q, drd_cnt_d;
    logic [WR_CW-1:0]  wr_cnt_q,  wr_cnt_d;
    logic              data_prio_q, data_prio_d;
    logic              arvalid_q, arvalid_d;
    logic [ID_W-1:0]   arid_q, arid_d;
    logic [31:0]       araddr_q, araddr_d;
    logic [2:0]        arsize_q, arsize_d;
    logic              awvalid_q, awvalid_d;
    logic [31:0]       awaddr_q, awaddr_d;
    logic [2:0]        awsize_q, awsize_d;
    logic              wvalid_q, wvalid_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              rdy_q;
    logic              inst_ok_q, inst_ok_d;
    logic              data_ok_q, data_ok_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

    // Decode
    logic ar_free_c, inst_elig_c, data_elig_c;
    logic inst_grant_c, data_grant_c, wr_accept_c;
    logic r_inst_c, r_data_c, b_ret_c;

    // AR slot eligibility, arbitration and write acceptance
    always_comb begin
        ar_free_c    = !arvalid_q || arready;
        inst_elig_c  = inst_sram_req && ar_free_c && (ird_cnt_q < RD_CW'(MAX_RD));
        data_elig_c  = data_sram_req && !data_sram_wr && ar_free_c
                       && (drd_cnt_q < RD_CW'(MAX_RD)) && (wr_cnt_q == '0);
        inst_grant_c = inst_elig_c && (!data_elig_c || !data_prio_q);
        data_grant_c = data_elig_c && (!inst_elig_c || data_prio_q);
        wr_accept_c  = data_sram_req && data_sram_wr
                       && (!awvalid_q || awready) && (!wvalid_q || wready)
                       && (wr_cnt_q < WR_CW'(MAX_WR)) && (drd_cnt_q == '0);
    end

    // Response routing; beats for a port with nothing outstanding are dropped
    always_comb begin
        r_inst_c = rvalid && rdy_q && (rid == ID_W'(0)) && (ird_cnt_q != '0);
        r_data_c = rvalid && rdy_q && (rid == ID_W'(1)) && (drd_cnt_q != '0);
        b_ret_c  = bvalid && rdy_q && (wr_cnt_q != '0);
    end

    // Next-state logic
    always_comb begin
        ird_cnt_d    = ird_cnt_q + RD_CW'(inst_grant_c) - RD_CW'(r_inst_c);
        drd_cnt_d    = drd_cnt_q + RD_CW'(data_grant_c) - RD_CW'(r_data_c);
        wr_cnt_d     = wr_cnt_q + WR_CW'(wr_accept_c) - WR_CW'(b_ret_c);
        data_prio_d  = data_prio_q;
        arvalid_d    = arvalid_q && !arready;
        arid_d       = arid_q;
        araddr_d     = araddr_q;
        arsize_d     = arsize_q;
        awvalid_d    = awvalid_q && !awready;
        awaddr_d     = awaddr_q;
        awsize_d     = awsize_q;
        wvalid_d     = wvalid_q && !wready;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        inst_ok_d    = r_inst_c;
        data_ok_d    = r_data_c || b_ret_c;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;

        // Loser of a contended grant wins the next contended one
        if (inst_elig_c && data_elig_c) begin
            data_prio_d = inst_grant_c;
        end
        if (inst_grant_c) begin
            arvalid_d = 1'b1;
            arid_d    = ID_W'(0);
            araddr_d  = inst_sram_addr;
            arsize_d  = inst_sram_size;
        end else if (data_grant_c) begin
            arvalid_d = 1'b1;
            arid_d    = ID_W'(1);
            araddr_d  = data_sram_addr;
            arsize_d  = data_sram_size;
        end
        if (wr_accept_c) begin
            awvalid_d = 1'b1;
            awaddr_d  = data_sram_addr;
            awsize_d  = data_sram_size;
            wvalid_d  = 1'b1;
            wdata_d   = data_sram_wdata;
            wstrb_d   = data_sram_wstrb;
        end
        if (r_inst_c) begin
            inst_rdata_d = rdata;
        end
        if (r_data_c) begin
            data_rdata_d = rdata;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ird_cnt_q    <= '0;
            drd_cnt_q    <= '0;
            wr_cnt_q     <= '0;
            data_prio_q  <= 1'b1;
            arvalid_q    <= 1'b0;
            arid_q       <= '0;
            araddr_q     <= '0;
            arsize_q     <= '0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            awsize_q     <= '0;
            wvalid_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdy_q        <= 1'b0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            ird_cnt_q    <= ird_cnt_d;
            drd_cnt_q    <= drd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            data_prio_q  <= data_prio_d;
            arvalid_q    <= arvalid_d;
            arid_q       <= arid_d;
            araddr_q     <= araddr_d;
            arsize_q     <= arsize_d;
            awvalid_q    <= awvalid_d;
            awaddr_q     <= awaddr_d;
            awsize_q     <= awsize_d;
            wvalid_q     <= wvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdy_q        <= 1'b1;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Outputs
    assign inst_sram_addr_ok = inst_grant_c;
    assign data_sram_addr_ok = data_grant_c || wr_accept_c;
    assign inst_sram_data_ok = inst_ok_q;
    assign data_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = inst_rdata_q;
    assign data_sram_rdata   = data_rdata_q;

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = 4'd0;
    assign arsize  = arsize_q;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = arvalid_q;
    assign rready  = rdy_q;

    assign awid    = ID_W'(1);
    assign awaddr  = awaddr_q;
    assign awlen   = 4'd0;
    assign awsize  = awsize_q;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = awvalid_q;

    assign wid     = ID_W'(1);
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;
    assign bready  = rdy_q;

    // Inputs that carry no meaning for this bridge
    logic unused_c;
    assign unused_c = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                        rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
module tb_cpu_axi_bridge;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned MAX_RD = 4;
    localparam int unsigned MAX_WR = 4;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    logic              inst_sram_req = 0, inst_sram_wr = 0;
    logic [2:0]        inst_sram_size = 0;
    logic [31:0]       inst_sram_addr = 0;
    logic [STRB_W-1:0] inst_sram_wstrb = 0;
    logic [DATA_W-1:0] inst_sram_wdata = 0;
    logic              inst_sram_addr_ok, inst_sram_data_ok;
    logic [DATA_W-1:0] inst_sram_rdata;
    logic              data_sram_req = 0, data_sram_wr = 0;
    logic [2:0]        data_sram_size = 0;
    logic [31:0]       data_sram_addr = 0;
    logic [STRB_W-1:0] data_sram_wstrb = 0;
    logic [DATA_W-1:0] data_sram_wdata = 0;
    logic              data_sram_addr_ok, data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;

    logic [ID_W-1:0]   arid, awid, wid;
    logic [31:0]       araddr, awaddr;
    logic [3:0]        arlen, arcache, awlen, awcache;
    logic [2:0]        arsize, arprot, awsize, awprot;
    logic [1:0]        arburst, arlock, awburst, awlock;
    logic              arvalid, awvalid, wvalid, wlast, rready, bready;
    logic              arready = 0, awready = 0, wready = 0;
    logic [ID_W-1:0]   rid = 0, bid = 0;
    logic [DATA_W-1:0] rdata = 0, wdata;
    logic [STRB_W-1:0] wstrb;
    logic [1:0]        rresp = 0, bresp = 0;
    logic              rlast = 1, rvalid = 0, bvalid = 0;

    cpu_axi_bridge #(.DATA_W(DATA_W), .ID_W(ID_W), .MAX_RD(MAX_RD), .MAX_WR(MAX_WR)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: outstanding counts as plain integers plus the
    // contents of the three address/data slots as the bus should show them.
    int          m_ird, m_drd, m_wr;
    bit          m_data_first;
    bit          m_rdy;
    bit          m_arv, m_awv, m_wv;
    logic [ID_W-1:0]   m_arid;
    logic [31:0]       m_araddr, m_awaddr;
    logic [2:0]        m_arsize, m_awsize;
    logic [DATA_W-1:0] m_wdata, m_irdata, m_drdata;
    logic [STRB_W-1:0] m_wstrb;
    bit          m_iok, m_dok;
    bit          s_iok, s_dok;

    function automatic void model_reset();
        m_ird = 0; m_drd = 0; m_wr = 0;
        m_data_first = 1'b1;
        m_rdy = 1'b0;
        m_arv = 0; m_awv = 0; m_wv = 0;
        m_iok = 0; m_dok = 0;
        m_irdata = '0; m_drdata = '0;
    endfunction

    // One clock: called at a negedge with inputs already set, returns at the next negedge
    task automatic step();
        bit free, ie, de, ig, dg, wa;
        #4;
        free = !m_arv || arready;
        ie = inst_sram_req && free && (m_ird < MAX_RD);
        de = data_sram_req && !data_sram_wr && free && (m_drd < MAX_RD) && (m_wr == 0);
        ig = ie && (!de || !m_data_first);
        dg = de && (!ie || m_data_first);
        wa = data_sram_req && data_sram_wr && (!m_awv || awready) && (!m_wv || wready)
             && (m_wr < MAX_WR) && (m_drd == 0);
        s_iok = inst_sram_addr_ok;
        s_dok = data_sram_addr_ok;
        chk("inst_addr_ok", 64'(s_iok), 64'(ig));
        chk("data_addr_ok", 64'(s_dok), 64'(dg || wa));
        chk("rready", 64'(rready), 64'(m_rdy));
        chk("bready", 64'(bready), 64'(m_rdy));
        @(posedge clk);
        m_iok = 0; m_dok = 0;
        if (rvalid && m_rdy) begin
            if (rid == 0 && m_ird > 0) begin m_iok = 1; m_irdata = rdata; m_ird--; end
            if (rid == 1 && m_drd > 0) begin m_dok = 1; m_drdata = rdata; m_drd--; end
        end
        if (bvalid && m_rdy && m_wr > 0) begin m_dok = 1; m_wr--; end
        if (ig) m_ird++;
        if (dg) m_drd++;
        if (wa) m_wr++;
        if (ig) begin m_arv = 1; m_arid = 0; m_araddr = inst_sram_addr; m_arsize = inst_sram_size; end
        else if (dg) begin m_arv = 1; m_arid = 1; m_araddr = data_sram_addr; m_arsize = data_sram_size; end
        else if (arready) m_arv = 0;
        if (ie && de) m_data_first = ig;
        if (wa) begin
            m_awv = 1; m_wv = 1;
            m_awaddr = data_sram_addr; m_awsize = data_sram_size;
            m_wdata = data_sram_wdata; m_wstrb = data_sram_wstrb;
        end else begin
            if (awready) m_awv = 0;
            if (wready) m_wv = 0;
        end
        m_rdy = 1;
        #1;
        chk("arvalid", 64'(arvalid), 64'(m_arv));
        if (m_arv) begin
            chk("arid", 64'(arid), 64'(m_arid));
            chk("araddr", 64'(araddr), 64'(m_araddr));
            chk("arsize", 64'(arsize), 64'(m_arsize));
        end
        chk("awvalid", 64'(awvalid), 64'(m_awv));
        chk("wvalid", 64'(wvalid), 64'(m_wv));
        if (m_awv) begin
            chk("awaddr", 64'(awaddr), 64'(m_awaddr));
            chk("awsize", 64'(awsize), 64'(m_awsize));
            chk("awid", 64'(awid), 64'd1);
        end
        if (m_wv) begin
            chk("wdata", 64'(wdata), 64'(m_wdata));
            chk("wstrb", 64'(wstrb), 64'(m_wstrb));
            chk("wid", 64'(wid), 64'd1);
        end
        chk("inst_data_ok", 64'(inst_sram_data_ok), 64'(m_iok));
        chk("data_data_ok", 64'(data_sram_data_ok), 64'(m_dok));
        if (m_iok) chk("inst_rdata", 64'(inst_sram_rdata), 64'(m_irdata));
        if (m_dok && m_drd >= 0 && !(bvalid && m_wr >= 0 && m_rdy && !(rvalid && rid == 1)))
            chk("data_rdata", 64'(data_sram_rdata), 64'(m_drdata));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_sram_req = 0; data_sram_req = 0; data_sram_wr = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rid = 0; bid = 1;
    endtask

    // Asynchronous reset pulse in the middle of the low phase
    task automatic do_reset();
        #2;
        resetn = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        bit ireq, dreq, dwr, ardy;
        bit exp_i, exp_d;
    } vec_t;
    vec_t tbl[11];

    logic [ID_W-1:0] rq[$];
    int aw_hs_n, w_hs_n, b_sent;

    initial begin
        logic [63:0] tmp;
        // Contention / counter limit table (from reset, no responses)
        tbl[0]  = '{1,1,0,1, 0,1};
        tbl[1]  = '{1,1,0,1, 1,0};
        tbl[2]  = '{1,1,0,1, 0,1};
        tbl[3]  = '{1,1,0,1, 1,0};
        tbl[4]  = '{0,1,1,1, 0,0};
        tbl[5]  = '{1,0,0,0, 1,0};
        tbl[6]  = '{1,1,0,0, 0,0};
        tbl[7]  = '{1,1,0,1, 0,1};
        tbl[8]  = '{1,1,0,1, 1,0};
        tbl[9]  = '{1,1,0,1, 0,1};
        tbl[10] = '{1,1,0,1, 0,0};

        model_reset();
        idle_inputs();
        @(negedge clk);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_data_rdata", 64'(data_sram_rdata), 64'd0);
        chk("rst_inst_rdata", 64'(inst_sram_rdata), 64'd0);
        resetn = 1'b1;
        chk("const_ax", {arlen, arburst, arlock, arcache, arprot, awlen, awburst, awlock, awcache, awprot, wlast},
            {4'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1});

        // Table-driven arbitration
        awready = 1; wready = 1;
        for (int i = 0; i < 11; i++) begin
            inst_sram_req = tbl[i].ireq;
            data_sram_req = tbl[i].dreq;
            data_sram_wr  = tbl[i].dwr;
            arready       = tbl[i].ardy;
            inst_sram_addr = 32'h1000 + 32'(i * 4);
            data_sram_addr = 32'h2000 + 32'(i * 4);
            inst_sram_size = 3'd2; data_sram_size = 3'd2;
            step();
            chk($sformatf("tbl%0d_i", i), 64'(s_iok), 64'(tbl[i].exp_i));
            chk($sformatf("tbl%0d_d", i), 64'(s_dok), 64'(tbl[i].exp_d));
            if (tbl[i].exp_i) chk($sformatf("tbl%0d_arid", i), 64'(arid), 64'd0);
            if (tbl[i].exp_d) chk($sformatf("tbl%0d_arid", i), 64'(arid), 64'd1);
            if (tbl[i].exp_i) chk($sformatf("tbl%0d_araddr", i), 64'(araddr), 64'(32'h1000 + 32'(i * 4)));
            if (tbl[i].exp_d) chk($sformatf("tbl%0d_araddr", i), 64'(araddr), 64'(32'h2000 + 32'(i * 4)));
        end

        // Back-to-back instruction reads, fifth blocked until an R beat
        do_reset();
        arready = 1; inst_sram_req = 1; inst_sram_size = 3'd2;
        for (int i = 0; i < 4; i++) begin
            inst_sram_addr = 32'h1000 + 32'(i * 4);
            step();
            chk("b2b_addr_ok", 64'(s_iok), 64'd1);
            chk("b2b_arvalid", 64'(arvalid), 64'd1);
        end
        inst_sram_addr = 32'h1010;
        step();
        chk("b2b_5th_blocked", 64'(s_iok), 64'd0);
        rvalid = 1; rid = 0; rdata = 64'h0123_4567_89AB_CDEF;
        step();
        chk("b2b_5th_blocked_rhs", 64'(s_iok), 64'd0);
        chk("b2b_inst_data_ok", 64'(inst_sram_data_ok), 64'd1);
        chk("b2b_inst_rdata", 64'(inst_sram_rdata), 64'h0123_4567_89AB_CDEF);
        rvalid = 0;
        step();
        chk("b2b_5th_granted", 64'(s_iok), 64'd1);

        // Write then dependent read, with a slow AW channel
        do_reset();
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h2000; data_sram_size = 3'd2;
        data_sram_wdata = 64'hAAAA_5555_1234_5678; data_sram_wstrb = 8'h0F;
        wready = 1; awready = 0;
        step();
        chk("wr_accept", 64'(s_dok), 64'd1);
        chk("wr_awvalid", 64'(awvalid), 64'd1);
        chk("wr_wvalid", 64'(wvalid), 64'd1);
        data_sram_wr = 0; data_sram_addr = 32'h2004; arready = 1;
        for (int i = 0; i < 3; i++) begin
            awready = (i == 2);
            step();
            chk("rd_held_by_wr", 64'(s_dok), 64'd0);
            if (i == 0) chk("wvalid_dropped", 64'(wvalid), 64'd0);
            if (i < 2) chk("awvalid_held", 64'(awvalid), 64'd1);
        end
        chk("awvalid_dropped", 64'(awvalid), 64'd0);
        step();
        chk("rd_held_before_b", 64'(s_dok), 64'd0);
        bvalid = 1;
        step();
        chk("rd_held_at_b", 64'(s_dok), 64'd0);
        chk("b_data_ok", 64'(data_sram_data_ok), 64'd1);
        bvalid = 0;
        step();
        chk("rd_after_b", 64'(s_dok), 64'd1);

        // 64-bit read, size 3
        do_reset();
        data_sram_req = 1; data_sram_addr = 32'h3008; data_sram_size = 3'd3;
        step();
        chk("w64_addr_ok", 64'(s_dok), 64'd1);
        chk("w64_arsize", 64'(arsize), 64'd3);
        chk("w64_araddr", 64'(araddr), 64'h3008);
        data_sram_req = 0; arready = 1;
        step();
        rvalid = 1; rid = 1; rdata = 64'hDEAD_BEEF_0123_4567;
        step();
        rvalid = 0;
        chk("w64_data_ok", 64'(data_sram_data_ok), 64'd1);
        chk("w64_rdata", 64'(data_sram_rdata), 64'hDEAD_BEEF_0123_4567);

        // Asynchronous reset with two data reads in flight and arvalid high
        do_reset();
        data_sram_req = 1; data_sram_size = 3'd2; arready = 1;
        data_sram_addr = 32'h4000; step();
        data_sram_addr = 32'h4004; step();
        chk("pre_rst_arvalid", 64'(arvalid), 64'd1);
        data_sram_req = 0; arready = 0;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_arvalid", 64'(arvalid), 64'd0);
        chk("async_rready", 64'(rready), 64'd0);
        chk("async_bready", 64'(bready), 64'd0);
        chk("async_data_ok", 64'(data_sram_data_ok), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        rvalid = 1; rid = 1; rdata = 64'h5A5A;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stale_r_dropped", 64'(data_sram_data_ok), 64'd0);
        end
        rvalid = 0;
        data_sram_req = 1; arready = 1;
        for (int i = 0; i < 4; i++) begin
            data_sram_addr = 32'h5000 + 32'(i * 4);
            step();
            chk("post_rst_cnt_clear", 64'(s_dok), 64'd1);
        end

        // Randomized traffic against the model, bench acting as the AXI slave
        do_reset();
        rq.delete();
        aw_hs_n = 0; w_hs_n = 0; b_sent = 0;
        for (int c = 0; c < 3000; c++) begin
            bit ar_hs, aw_hs, w_hs, rdy, r_go, b_go;
            inst_sram_req  = ($urandom % 4) != 0;
            inst_sram_addr = $urandom;
            inst_sram_size = 3'($urandom % 4);
            data_sram_req  = ($urandom % 4) != 0;
            data_sram_wr   = ($urandom % 3) == 0;
            data_sram_addr = $urandom;
            data_sram_size = 3'($urandom % 4);
            data_sram_wdata = {$urandom, $urandom};
            data_sram_wstrb = 8'($urandom);
            arready = ($urandom % 4) != 0;
            awready = ($urandom % 3) != 0;
            wready  = ($urandom % 3) != 0;
            r_go = (rq.size() > 0) && ($urandom % 2);
            rvalid = r_go;
            if (r_go) begin rid = rq[0]; rdata = {$urandom, $urandom}; end
            b_go = (b_sent < aw_hs_n) && (b_sent < w_hs_n) && ($urandom % 2);
            bvalid = b_go;
            ar_hs = arvalid && arready;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            rdy = m_rdy;
            tmp = {60'd0, arid};
            step();
            if (ar_hs) rq.push_back(ID_W'(tmp));
            if (aw_hs) aw_hs_n++;
            if (w_hs) w_hs_n++;
            if (r_go && rdy) void'(rq.pop_front());
            if (b_go && rdy) b_sent++;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Parametrised successor to the single-outstanding CPU-to-AXI bridge. It converts the CPU's two SRAM-like ports (instruction and data) into one AXI3 master port, and sits between the CPU core and the AXI crossbar. Relative to the first generation it adds:
- configurable data width;
- multiple outstanding reads per port and multiple outstanding writes;
- fair AR arbitration;
- back-to-back issue with no idle cycles between transactions.

## Interface
Parameters:
- DATA_W, 32, data bus width in bits; 32 or 64.
- ID_W, 4, AXI ID width.
- MAX_RD, 4, maximum outstanding reads per SRAM port; 1..8.
- MAX_WR, 4, maximum outstanding writes; 1..8.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_sram_req/wr  in  1  request valid / write flag. inst_sram_wr=1 is illegal and ignored.
- inst_sram_size  in  3  log2 of the byte count.
- inst_sram_addr  in  32  byte address.
- inst_sram_wstrb / wdata  in  DATA_W/8 / DATA_W  unused on this port.
- inst_sram_addr_ok  out  1  request accepted this cycle (combinational).
- inst_sram_data_ok  out  1  one-cycle response pulse.
- inst_sram_rdata  out  DATA_W  read data, valid with data_ok.
- data_sram_*  same set as inst_sram_*; writes are legal on this port.
- AXI3 master channels, all ports named as in the first generation:
  - ar*: arid[ID_W], araddr[32], arlen, arsize, arburst, arlock, arcache, arprot, arvalid, arready.
  - r*: rid, rdata[DATA_W], rresp, rlast, rvalid, rready.
  - aw*: same set as ar*.
  - w*: wid, wdata, wstrb[DATA_W/8], wlast, wvalid, wready.
  - b*: bid, bresp, bvalid, bready.

## Operation
- Constant outputs:
  - arlen = awlen = 0; arburst = awburst = INCR; lock, cache and prot all zero; wlast = 1.
  - IDs: instruction reads use ID 0; data reads, writes and W beats use ID 1.
- Transfer size: axsize = the SRAM port's size field, passed unchanged. The address is passed unaligned.
- Counters, each of width clog2(MAX+1):
  - ird_cnt, drd_cnt: outstanding instruction and data reads.
  - wr_cnt: outstanding writes.
  - A counter is incremented on request acceptance and decremented on the matching R or B handshake. Both in the same cycle leaves the count unchanged.
- AR slot:
  - The slot is free when !arvalid || arready.
  - inst read is eligible when: req && free && ird_cnt < MAX_RD.
  - data read is eligible when: req && !wr && free && drd_cnt < MAX_RD && wr_cnt == 0.
- AR arbitration:
  - If only one port is eligible, that port wins.
  - If both are eligible, the port that lost the previous contended grant wins. After reset, data has priority.
  - The winner gets addr_ok in the same cycle. The AR register loads on that edge.
- Write acceptance:
  - A data write is accepted when: req && wr && (!awvalid || awready) && (!wvalid || wready) && wr_cnt < MAX_WR && drd_cnt == 0.
  - On acceptance, awvalid and wvalid are both set. Each drops independently on its own handshake unless a new write is loaded in the same cycle.
- Data-port ordering: reads and writes never overlap on the data port. This keeps data_ok in request order without a reorder buffer.
- The instruction port is not ordered against data writes. Software issues a barrier before executing stored code.
- Responses:
  - rready = 1 and bready = 1 whenever not in reset.
  - R handshake: rid == 0 routes to inst, rid == 1 to data.
  - If the routed counter is zero, the beat is dropped and no data_ok pulses.
  - B handshake pulses data_ok on the data port.
  - rresp and bresp are ignored.
- Reset, including mid-operation:
  - All valids, counters, the arbitration bit and data_ok clear immediately. rready and bready go to 0.
  - rdata outputs reset to 0.
  - Responses arriving after reset for pre-reset requests are dropped because the counters read zero.

## Timing
- Read path:
  - Request accepted at cycle N (addr_ok high at N).
  - arvalid rises at N+1.
  - rdata/data_ok are registered: data_ok is high on the cycle after the R handshake.
  - Minimum latency: R handshake at N+2, data_ok at N+3.
- Write path:
  - Accepted at N; awvalid/wvalid high at N+1.
  - B handshake at cycle M gives data_ok at M+1.
- Back-to-back AR issue: when arready is held high, a new AR is loaded every cycle.
- A single cycle can contain both an inst R data_ok and a data B data_ok; both pulse.
- addr_ok is low whenever req is low. addr_ok never depends on arready of a future cycle.

## Test plan
- Reset: resetn low mid-burst with arvalid = 1 and drd_cnt = 2.
  - Required: all valids and counters are 0 asynchronously.
  - Required: a later rvalid with rid = 1 produces no data_ok.
- Back-to-back reads: inst issues 4 reads to 0x1000..0x100C, arready = 1, MAX_RD = 4.
  - Required: 4 consecutive addr_ok pulses and arvalid high for 4 cycles.
  - Required: a 5th request gets no addr_ok until the first R handshake.
- Contention: inst and data both request every cycle.
  - Required: AR grants alternate D, I, D, I; araddr and arid follow.
- Write/read separation: data write to 0x2000, then data read to 0x2004.
  - Required: the read's addr_ok is held low until the cycle the B handshake retires the write, i.e. wr_cnt returns to 0.
- Write channels independent: awready is delayed 3 cycles while wready = 1.
  - Required: wvalid drops after one cycle; awvalid stays high until awready.
  - Required: data_ok comes 1 cycle after bvalid.
- DATA_W = 64: size = 3, read at 0x3008.
  - Required: arsize = 3, and all 64 bits of rdata appear on data_sram_rdata with data_ok.
